dcache_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single data-cache request/response port between the core's data-memory path (port 1) and the init/loader path (port 0). It selects one request per transfer, holds the grant stable while the cache stalls, and tracks outstanding reads in order so each read response is routed back to the port that issued it. It sits between the requesters and the cache; the cache is unaware of more than one master.

---
 rtl/dcache_arb_pkg.sv | 33 +++
 rtl/arb_id_fifo.sv | 66 ++++++
 rtl/dcache_port_arbiter.sv | 121 ++++++++++++
 tb/tb_dcache_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared types for the data-cache port arbiter: port identifiers, the
// request payload carried through the grant mux, and the grant choice.
package dcache_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT_INIT = 1'b0;
  localparam port_id_t PORT_CORE = 1'b1;

  // Address bits carried inside the request payload; the top's address
  // parameter must not exceed this.
  localparam int ADDR_W = 25;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              wr;    // 0 = write, 1 = read
  } req_t;

  // Grant choice when no lock is held. With nothing valid the core port is
  // selected so the cache payload defaults to port 1.
  function automatic port_id_t pick_port(input logic v0, input logic v1,
                                         input logic fixed_prio,
                                         input port_id_t last_id);
    if (v0 && v1) begin
      return fixed_prio ? PORT_INIT : port_id_t'(~last_id);
    end else if (v0) begin
      return PORT_INIT;
    end
    return PORT_CORE;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit port IDs for reads that are in flight at the cache.
// The head is read combinationally so a response is routed in the cycle it
// arrives.
module arb_id_fifo
  import dcache_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  port_id_t               push_id,
  input  logic                   pop,
  output port_id_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  port_id_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees a slot.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each slot captures the pushed ID when the write pointer targets it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mem[gi] <= PORT_INIT;
        end else if (do_push && (wr_ptr == PW'(gi))) begin
          mem[gi] <= push_id;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one data-cache request/response port between the init/loader path
// (port 0) and the core data path (port 1). Requests are muxed with zero
// latency; read responses are steered back using an in-order ID FIFO.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int Addresswidth    = 25,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIXED_PRIO      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [Addresswidth-1:0] m0_req_addr,
  input  logic [31:0]             m0_req_data,
  input  logic                    m0_req_wr,
  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  output logic [31:0]             m0_rsp_data,
  output logic                    m0_rsp_valid,
  input  logic [Addresswidth-1:0] m1_req_addr,
  input  logic [31:0]             m1_req_data,
  input  logic                    m1_req_wr,
  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  output logic [31:0]             m1_rsp_data,
  output logic                    m1_rsp_valid,
  output logic [Addresswidth-1:0] cache_req_addr,
  output logic [31:0]             cache_req_data,
  output logic                    cache_req_wr,
  output logic                    cache_req_valid,
  input  logic                    cache_req_ready,
  input  logic [31:0]             cache_rsp_data,
  input  logic                    cache_rsp_valid,
  output logic                    rsp_err,
  output logic                    idle
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  req_t            req0;
  req_t            req1;
  req_t            sel;
  port_id_t        grant;
  port_id_t        last_id;
  port_id_t        lock_id;
  port_id_t        fifo_head;
  logic            locked;
  logic            grant_valid;
  logic            transfer;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign req0 = {ADDR_W'(m0_req_addr), m0_req_data, m0_req_wr};
  assign req1 = {ADDR_W'(m1_req_addr), m1_req_data, m1_req_wr};

  // Grant selection: a held lock overrides arbitration so the payload stays
  // stable while the cache stalls.
  always_comb begin
    grant = pick_port(m0_req_valid, m1_req_valid, FIXED_PRIO != 0, last_id);
    if (locked) grant = lock_id;
  end

  assign sel         = (grant == PORT_INIT) ? req0 : req1;
  assign grant_valid = (grant == PORT_INIT) ? m0_req_valid : m1_req_valid;

  assign cache_req_addr = Addresswidth'(sel.addr);
  assign cache_req_data = sel.data;
  assign cache_req_wr   = sel.wr;
  // Reads are held back while the ID FIFO is full, unless a response frees
  // a slot in the same cycle. Writes never need a slot.
  assign cache_req_valid = grant_valid & (~sel.wr | ~fifo_full | cache_rsp_valid);
  assign transfer        = cache_req_valid & cache_req_ready;

  assign m0_req_ready = (grant == PORT_INIT) & transfer;
  assign m1_req_ready = (grant == PORT_CORE) & transfer;

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (transfer & sel.wr),
    .push_id (grant),
    .pop     (cache_rsp_valid),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m0_rsp_data  = cache_rsp_data;
  assign m1_rsp_data  = cache_rsp_data;
  assign m0_rsp_valid = cache_rsp_valid & ~fifo_empty & (fifo_head == PORT_INIT);
  assign m1_rsp_valid = cache_rsp_valid & ~fifo_empty & (fifo_head == PORT_CORE);

  assign idle = (fifo_count == '0) & ~locked;

  // Lock tracks a granted-but-not-transferred request; last_id feeds the
  // round-robin choice; rsp_err latches any response with nothing in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked  <= 1'b0;
      lock_id <= PORT_CORE;
      last_id <= PORT_CORE;
      rsp_err <= 1'b0;
    end else begin
      if (transfer) begin
        locked  <= 1'b0;
        last_id <= grant;
      end else if (grant_valid) begin
        locked  <= 1'b1;
        lock_id <= grant;
      end else begin
        locked  <= 1'b0;
      end
      if (cache_rsp_valid && fifo_empty) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: one task per scenario, inline
// checks against hand-computed values.
module tb_dcache_port_arbiter;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_req_addr, m1_req_addr, cache_req_addr;
  logic [31:0]   m0_req_data, m1_req_data, cache_req_data;
  logic          m0_req_wr, m1_req_wr, cache_req_wr;
  logic          m0_req_valid, m1_req_valid, cache_req_valid;
  logic          m0_req_ready, m1_req_ready, cache_req_ready;
  logic [31:0]   m0_rsp_data, m1_rsp_data, cache_rsp_data;
  logic          m0_rsp_valid, m1_rsp_valid, cache_rsp_valid;
  logic          rsp_err, idle;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(
    .Addresswidth    (AW),
    .MAX_OUTSTANDING (4),
    .FIXED_PRIO      (0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m0_req_addr     (m0_req_addr),
    .m0_req_data     (m0_req_data),
    .m0_req_wr       (m0_req_wr),
    .m0_req_valid    (m0_req_valid),
    .m0_req_ready    (m0_req_ready),
    .m0_rsp_data     (m0_rsp_data),
    .m0_rsp_valid    (m0_rsp_valid),
    .m1_req_addr     (m1_req_addr),
    .m1_req_data     (m1_req_data),
    .m1_req_wr       (m1_req_wr),
    .m1_req_valid    (m1_req_valid),
    .m1_req_ready    (m1_req_ready),
    .m1_rsp_data     (m1_rsp_data),
    .m1_rsp_valid    (m1_rsp_valid),
    .cache_req_addr  (cache_req_addr),
    .cache_req_data  (cache_req_data),
    .cache_req_wr    (cache_req_wr),
    .cache_req_valid (cache_req_valid),
    .cache_req_ready (cache_req_ready),
    .cache_rsp_data  (cache_rsp_data),
    .cache_rsp_valid (cache_rsp_valid),
    .rsp_err         (rsp_err),
    .idle            (idle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_req_addr = '0; m0_req_data = '0; m0_req_wr = 1'b1; m0_req_valid = 1'b0;
    m1_req_addr = 25'h55; m1_req_data = 32'h1111; m1_req_wr = 1'b1; m1_req_valid = 1'b0;
    cache_req_ready = 1'b0; cache_rsp_data = '0; cache_rsp_valid = 1'b0;
    #2;
    n_cmp++; if (m0_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m0_ready got %b exp 0", m0_req_ready); end
    n_cmp++; if (m1_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m1_ready got %b exp 0", m1_req_ready); end
    n_cmp++; if (cache_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cache_valid got %b exp 0", cache_req_valid); end
    n_cmp++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", {m0_rsp_valid, m1_rsp_valid}); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", idle); end
    n_cmp++; if (cache_req_addr !== 25'h55) begin n_fail++; $display("FAIL reset_addr_default got %h exp 55", cache_req_addr); end
    tick();
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    m1_req_addr = 25'h10; m1_req_wr = 1'b1; m1_req_valid = 1'b1; cache_req_ready = 1'b1;
    #1;
    n_cmp++; if (cache_req_valid !== 1'b1) begin n_fail++; $display("FAIL single_cache_valid got %b exp 1", cache_req_valid); end
    n_cmp++; if (cache_req_addr !== 25'h10) begin n_fail++; $display("FAIL single_addr got %h exp 10", cache_req_addr); end
    n_cmp++; if ({m0_req_ready, m1_req_ready} !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b exp 01", {m0_req_ready, m1_req_ready}); end
    tick();
    m1_req_valid = 1'b0;
    #1;
    n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b exp 0", idle); end
    tick();
    cache_rsp_valid = 1'b1; cache_rsp_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b01) begin n_fail++; $display("FAIL single_rsp_route got %b exp 01", {m0_rsp_valid, m1_rsp_valid}); end
    n_cmp++; if (m1_rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rsp_data got %h exp deadbeef", m1_rsp_data); end
    tick();
    cache_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_after got %b exp 1", idle); end
    $display("test_single_read done");
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr [4];
    logic [1:0]    exp_rdy  [4];
    logic [1:0]    exp_rsp  [4];
    exp_addr[0] = 25'h100; exp_addr[1] = 25'h200; exp_addr[2] = 25'h100; exp_addr[3] = 25'h200;
    exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10; exp_rdy[3] = 2'b01;
    exp_rsp[0] = 2'b10; exp_rsp[1] = 2'b01; exp_rsp[2] = 2'b10; exp_rsp[3] = 2'b01;
    m0_req_addr = 25'h100; m0_req_wr = 1'b1; m0_req_valid = 1'b1;
    m1_req_addr = 25'h200; m1_req_wr = 1'b1; m1_req_valid = 1'b1;
    cache_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (cache_req_addr !== exp_addr[k]) begin n_fail++; $display("FAIL rr_addr[%0d] got %h exp %h", k, cache_req_addr, exp_addr[k]); end
      n_cmp++; if ({m0_req_ready, m1_req_ready} !== exp_rdy[k]) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", k, {m0_req_ready, m1_req_ready}, exp_rdy[k]); end
      tick();
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cache_rsp_valid = 1'b1; cache_rsp_data = 32'h1000 + k;
      #1;
      n_cmp++; if ({m0_rsp_valid, m1_rsp_valid} !== exp_rsp[k]) begin n_fail++; $display("FAIL rr_rsp[%0d] got %b exp %b", k, {m0_rsp_valid, m1_rsp_valid}, exp_rsp[k]); end
      tick();
    end
    cache_rsp_valid = 1'b0;
    $display("test_round_robin done");
  endtask

  task automatic test_lock();
    cache_req_ready = 1'b0;
    m1_req_addr = 25'h300; m1_req_wr = 1'b1; m1_req_valid = 1'b1;
    #1;
    n_cmp++; if (cache_req_addr !== 25'h300) begin n_fail++; $display("FAIL lock_c0_addr got %h exp 300", cache_req_addr); end
    n_cmp++; if (m1_req_ready !== 1'b0) begin n_fail++; $display("FAIL lock_c0_ready got %b exp 0", m1_req_ready); end
    tick();
    #1;
    n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL lock_idle got %b exp 0", idle); end
    tick();
    m0_req_addr = 25'h400; m0_req_wr = 1'b1; m0_req_valid = 1'b1;
    #1;
    n_cmp++; if (cache_req_addr !== 25'h300) begin n_fail++; $display("FAIL lock_hold_addr got %h exp 300", cache_req_addr); end
    tick();
    cache_req_ready = 1'b1;
    #1;
    n_cmp++; if ({m0_req_ready, m1_req_ready} !== 2'b01) begin n_fail++; $display("FAIL lock_release_ready got %b exp 01", {m0_req_ready, m1_req_ready}); end
    tick();
    m1_req_addr = 25'h304;
    #1;
    n_cmp++; if (cache_req_addr !== 25'h400) begin n_fail++; $display("FAIL lock_next_addr got %h exp 400", cache_req_addr); end
    n_cmp++; if ({m0_req_ready, m1_req_ready} !== 2'b10) begin n_fail++; $display("FAIL lock_next_ready got %b exp 10", {m0_req_ready, m1_req_ready}); end
    tick();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    cache_rsp_valid = 1'b1; cache_rsp_data = 32'hA;
    #1;
    n_cmp++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b01) begin n_fail++; $display("FAIL lock_rsp0 got %b exp 01", {m0_rsp_valid, m1_rsp_valid}); end
    tick();
    cache_rsp_data = 32'hB;
    #1;
    n_cmp++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL lock_rsp1 got %b exp 10", {m0_rsp_valid, m1_rsp_valid}); end
    tick();
    cache_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL lock_idle_end got %b exp 1", idle); end
    $display("test_lock done");
  endtask

  task automatic test_full();
    cache_req_ready = 1'b1;
    m0_req_wr = 1'b1; m0_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m0_req_addr = 25'h500 + k;
      #1;
      n_cmp++; if (m0_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_ready[%0d] got %b exp 1", k, m0_req_ready); end
      tick();
    end
    m0_req_valid = 1'b0;
    m1_req_addr = 25'h600; m1_req_wr = 1'b0; m1_req_data = 32'h5A5A; m1_req_valid = 1'b1;
    #1;
    n_cmp++; if ({cache_req_valid, m1_req_ready} !== 2'b11) begin n_fail++; $display("FAIL full_write_pass got %b exp 11", {cache_req_valid, m1_req_ready}); end
    n_cmp++; if (cache_req_data !== 32'h5A5A) begin n_fail++; $display("FAIL full_write_data got %h exp 5a5a", cache_req_data); end
    tick();
    m1_req_valid = 1'b0; m1_req_wr = 1'b1;
    m0_req_addr = 25'h700; m0_req_valid = 1'b1;
    #1;
    n_cmp++; if ({cache_req_valid, m0_req_ready} !== 2'b00) begin n_fail++; $display("FAIL full_read_block got %b exp 00", {cache_req_valid, m0_req_ready}); end
    tick();
    cache_rsp_valid = 1'b1; cache_rsp_data = 32'hC;
    #1;
    n_cmp++; if ({cache_req_valid, m0_req_ready, m0_rsp_valid} !== 3'b111) begin n_fail++; $display("FAIL full_admit_on_pop got %b exp 111", {cache_req_valid, m0_req_ready, m0_rsp_valid}); end
    tick();
    m0_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL full_drain[%0d] got %b exp 10", k, {m0_rsp_valid, m1_rsp_valid}); end
      tick();
    end
    cache_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL full_idle_end got %b exp 1", idle); end
    $display("test_full done");
  endtask

  task automatic test_spurious();
    n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL spur_idle_pre got %b exp 1", idle); end
    cache_rsp_valid = 1'b1; cache_rsp_data = 32'hBAD;
    #1;
    n_cmp++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL spur_rsp_valid got %b exp 00", {m0_rsp_valid, m1_rsp_valid}); end
    tick();
    cache_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL spur_err_set got %b exp 1", rsp_err); end
    tick();
    tick();
    n_cmp++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL spur_err_sticky got %b exp 1", rsp_err); end
    $display("test_spurious done");
  endtask

  task automatic test_reset_mid();
    cache_req_ready = 1'b1;
    m0_req_addr = 25'h800; m0_req_wr = 1'b1; m0_req_valid = 1'b1;
    tick();
    tick();
    m0_req_valid = 1'b0;
    cache_req_ready = 1'b0;
    m1_req_addr = 25'h900; m1_req_wr = 1'b1; m1_req_valid = 1'b1;
    tick();
    #1;
    n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", idle); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({idle, rsp_err} !== 2'b10) begin n_fail++; $display("FAIL rmid_reset_state got %b exp 10", {idle, rsp_err}); end
    tick();
    reset = 1'b0;
    m0_req_addr = 25'h910; m0_req_valid = 1'b1;
    cache_req_ready = 1'b1;
    #1;
    n_cmp++; if (cache_req_addr !== 25'h910) begin n_fail++; $display("FAIL rmid_first_grant got %h exp 910", cache_req_addr); end
    n_cmp++; if ({m0_req_ready, m1_req_ready} !== 2'b10) begin n_fail++; $display("FAIL rmid_ready got %b exp 10", {m0_req_ready, m1_req_ready}); end
    tick();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    tick();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_full();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
